// File: rtl/uart_rx_mv.sv
// UART receive front-end: synchronises RxD, samples each bit three times around mid-bit
// and majority-votes, producing character strobes, framing/break flags and a good-character count.
module uart_rx_mv #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rxd,
    input  logic             rx_en,
    input  logic [WIDTH-1:0] cycles_per_bit,
    output logic             rx_valid,
    output logic [7:0]       rx_data,
    output logic             rx_break,
    output logic             frame_err,
    output logic [31:0]      char_count
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK_WAIT} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sync;
    logic                   rs, rs_d;
    logic [WIDTH-1:0]       cpb_l, cc, brk_cnt, half;
    logic [2:0]             bit_idx;
    logic [7:0]             shift;
    logic                   s0, s1;
    logic                   maj, at_dec, at_end, start_edge, in_frame, brk_done, stop_dec;

    assign rs         = sync[SYNC_STAGES-1];
    assign half       = cpb_l >> 1;
    assign at_dec     = (cc == half + WIDTH'(1));
    assign at_end     = (cc == cpb_l - WIDTH'(1));
    assign maj        = (s0 & s1) | (s0 & rs) | (s1 & rs);
    assign start_edge = rx_en && rs_d && !rs;
    assign in_frame   = (state == START) || (state == DATA) || (state == STOP);
    assign brk_done   = rs && (brk_cnt == half - WIDTH'(1));
    assign stop_dec   = rx_en && (state == STOP) && at_dec;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start_edge) state_next = START;
            // A start bit that votes high is treated as a glitch, not a frame.
            START:    if (at_dec && maj) state_next = IDLE;
                      else if (at_end)   state_next = DATA;
            DATA:     if (at_end && bit_idx == 3'd7) state_next = STOP;
            STOP:     if (at_dec) state_next = maj ? IDLE : BRK_WAIT;
            BRK_WAIT: if (brk_done) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (!rx_en) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sync       <= '1;
            rs_d       <= 1'b1;
            cpb_l      <= '0;
            cc         <= '0;
            brk_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            s0         <= 1'b0;
            s1         <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            rx_break   <= 1'b0;
            frame_err  <= 1'b0;
            char_count <= '0;
        end else begin
            state     <= state_next;
            sync      <= {sync[SYNC_STAGES-2:0], rxd};
            rs_d      <= rs;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            if (state == IDLE && start_edge) begin
                cc    <= '0;
                cpb_l <= (cycles_per_bit < WIDTH'(4)) ? WIDTH'(4) : cycles_per_bit;
            end else if (in_frame) begin
                cc <= at_end ? '0 : cc + WIDTH'(1);
                if (cc == half - WIDTH'(1)) s0 <= rs;
                if (cc == half)             s1 <= rs;
                if (state == START && at_end) bit_idx <= '0;
                if (state == DATA) begin
                    if (at_dec) shift   <= {maj, shift[7:1]};
                    if (at_end) bit_idx <= bit_idx + 3'd1;
                end
            end

            // Counts consecutive high line cycles while waiting out a break or bad stop bit.
            if (state == BRK_WAIT) brk_cnt <= rs ? brk_cnt + WIDTH'(1) : '0;
            else                   brk_cnt <= '0;

            if (stop_dec) begin
                if (maj) begin
                    rx_valid   <= 1'b1;
                    rx_data    <= shift;
                    char_count <= char_count + 32'd1;
                end else if (shift != 8'd0) begin
                    frame_err <= 1'b1;
                end else begin
                    rx_break <= 1'b1;
                end
            end

            if (!rx_en || (state == BRK_WAIT && brk_done)) rx_break <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_mv.sv
// Directed + randomized bench for uart_rx_mv; a frame-level model predicts strobes,
// data and counts, and a monitor collects what the receiver actually emitted.
module tb_uart_rx_mv;

    logic        clk = 1'b0;
    logic        reset, rxd, rx_en;
    logic [31:0] cycles_per_bit;
    logic        rx_valid, rx_break, frame_err;
    logic [7:0]  rx_data;
    logic [31:0] char_count;

    uart_rx_mv #(.WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .rx_en(rx_en),
        .cycles_per_bit(cycles_per_bit), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_break(rx_break), .frame_err(frame_err), .char_count(char_count)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0, failures = 0;

    int unsigned valid_cnt = 0, ferr_cnt = 0, double_cnt = 0, cyc = 0, valid_cyc = 0;
    logic        prev_valid = 1'b0;
    logic [7:0]  got_q[$];

    int unsigned exp_valid = 0, exp_ferr = 0;
    logic [31:0] exp_count = 0;
    logic [7:0]  exp_data = 0;
    logic [7:0]  exp_q[$];

    always @(negedge clk) begin
        cyc++;
        if (rx_valid === 1'b1) begin
            valid_cnt++;
            valid_cyc = cyc;
            got_q.push_back(rx_data);
            if (prev_valid === 1'b1) double_cnt++;
        end
        if (frame_err === 1'b1) ferr_cnt++;
        prev_valid = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // A clean frame delivers its byte; a low stop bit gives a framing error unless all data is zero (break).
    task automatic model_frame(input logic [7:0] d, input logic stop_bit);
        if (stop_bit) begin
            exp_valid++;
            exp_data = d;
            exp_count = exp_count + 32'd1;
            exp_q.push_back(d);
        end else if (d != 8'd0) begin
            exp_ferr++;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int unsigned cpb, input logic stop_bit,
                              input int noise, input int abort_bit, input bit scramble);
        logic [9:0] bits;
        logic       v;
        bits = {stop_bit, d, 1'b0};
        for (int unsigned b = 0; b < 10; b++) begin
            for (int unsigned c = 0; c < cpb; c++) begin
                v = bits[b];
                if (int'(b * cpb + c) == noise) v = ~v;
                if (abort_bit >= 0 && int'(b) == abort_bit + 1 && c == 0) rx_en = 1'b0;
                if (scramble && b == 5 && c == 0) cycles_per_bit = $urandom_range(4, 40);
                rxd = v;
                step(1);
            end
        end
        rxd = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".valid_cnt"}, valid_cnt, exp_valid);
        check({tag, ".ferr_cnt"}, ferr_cnt, exp_ferr);
        check({tag, ".char_count"}, char_count, exp_count);
        check({tag, ".rx_data"}, {24'd0, rx_data}, {24'd0, exp_data});
        check({tag, ".double_valid"}, double_cnt, 0);
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, ".char"}, {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
    endtask

    initial begin
        int unsigned start_cyc, cpb;
        logic [7:0]  d;
        bit          scr;

        reset = 1'b1;
        rxd = 1'b1;
        rx_en = 1'b0;
        cycles_per_bit = 32'd8;
        step(3);
        reset = 1'b0;
        step(1);
        check("reset.rx_valid", {31'd0, rx_valid}, 0);
        check("reset.rx_data", {24'd0, rx_data}, 0);
        check("reset.rx_break", {31'd0, rx_break}, 0);
        check("reset.frame_err", {31'd0, frame_err}, 0);
        check("reset.char_count", char_count, 0);

        // Reset in the middle of a frame must not emit anything.
        rx_en = 1'b1;
        rxd = 1'b0;
        step(20);
        reset = 1'b1;
        rxd = 1'b1;
        step(3);
        reset = 1'b0;
        step(20);
        check_state("midreset");

        // Normal character, with a latency window on the strobe.
        cycles_per_bit = 32'd8;
        start_cyc = cyc;
        send_frame(8'h55, 8, 1'b1, -1, -1, 1'b0);
        model_frame(8'h55, 1'b1);
        step(4);
        check_state("normal");
        check("normal.latency_window",
              {31'd0, (valid_cyc - start_cyc >= 76) && (valid_cyc - start_cyc <= 88)}, 1);

        // Short low glitch is rejected, then a real frame follows.
        cycles_per_bit = 32'd16;
        rxd = 1'b0;
        step(2);
        rxd = 1'b1;
        step(40);
        check_state("glitch");
        send_frame(8'hA3, 16, 1'b1, -1, -1, 1'b0);
        model_frame(8'hA3, 1'b1);
        step(4);
        check_state("after_glitch");

        // One inverted cycle at the centre sample of data bit 2.
        send_frame(8'h0F, 16, 1'b1, 3 * 16 + 8 + 1, -1, 1'b0);
        model_frame(8'h0F, 1'b1);
        step(4);
        check_state("noise");

        // Framing error.
        cycles_per_bit = 32'd8;
        send_frame(8'hA5, 8, 1'b0, -1, -1, 1'b0);
        model_frame(8'hA5, 1'b0);
        step(24);
        check_state("frame_err");
        check("frame_err.rx_break", {31'd0, rx_break}, 0);

        // Line break: 20 bit times low.
        rxd = 1'b0;
        step(160);
        check("break.held", {31'd0, rx_break}, 1);
        rxd = 1'b1;
        step(2);
        check("break.release_early", {31'd0, rx_break}, 1);
        step(8);
        check("break.cleared", {31'd0, rx_break}, 0);
        step(10);
        check_state("break");

        // Back-to-back characters.
        send_frame(8'h31, 8, 1'b1, -1, -1, 1'b0);
        model_frame(8'h31, 1'b1);
        send_frame(8'h32, 8, 1'b1, -1, -1, 1'b0);
        model_frame(8'h32, 1'b1);
        step(4);
        check_state("back2back");

        // Abort at data bit 4: no strobes, and the receiver is ready afterwards.
        send_frame(8'h7E, 8, 1'b1, -1, 4, 1'b0);
        step(10);
        check_state("abort");
        check("abort.rx_break", {31'd0, rx_break}, 0);
        rx_en = 1'b1;
        step(5);
        send_frame(8'h7E, 8, 1'b1, -1, -1, 1'b0);
        model_frame(8'h7E, 1'b1);
        step(4);
        check_state("after_abort");

        // Period below the minimum is clamped to 4.
        cycles_per_bit = 32'd2;
        send_frame(8'hC6, 4, 1'b1, -1, -1, 1'b0);
        model_frame(8'hC6, 1'b1);
        step(4);
        check_state("clamp");

        // Randomized characters and periods; some change cycles_per_bit mid-frame.
        for (int i = 0; i < 8; i++) begin
            cpb = $urandom_range(4, 12);
            d = 8'($urandom);
            scr = 1'($urandom_range(0, 1));
            cycles_per_bit = cpb;
            send_frame(d, cpb, 1'b1, -1, -1, scr);
            model_frame(d, 1'b1);
            step($urandom_range(0, 4));
        end
        step(4);
        check_state("random");

        // Character count wraps to zero.
        cycles_per_bit = 32'd8;
        force dut.char_count = 32'hFFFF_FFFF;
        step(1);
        release dut.char_count;
        exp_count = 32'hFFFF_FFFF;
        send_frame(8'h5A, 8, 1'b1, -1, -1, 1'b0);
        model_frame(8'h5A, 1'b1);
        step(4);
        check_state("wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_mv.md
Name: uart_rx_mv

Overview:
- Serial receive front-end for the UART peripheral.
- Samples the asynchronous RxD line with a programmable bit period and majority-votes three samples per bit.
- Delivers one-cycle character strobes, a break flag and a running character count to the peripheral's receive FSM and Rx FIFO.
- Upstream stage of the Rx queue: its rx_valid pulse is the FIFO write trigger.

Parameters:
- WIDTH, 32, width of cycles_per_bit input.
- SYNC_STAGES, 2, number of flip-flops in the RxD synchroniser (minimum 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rxd  input  1  asynchronous serial line, idle high.
- rx_en  input  1  receiver enable; low aborts and holds in IDLE.
- cycles_per_bit  input  WIDTH  bit period in clk cycles.
- rx_valid  output  1  one-cycle strobe: rx_data holds a new character.
- rx_data  output  8  last good character, LSB first on line.
- rx_break  output  1  line-break condition present.
- frame_err  output  1  one-cycle strobe: stop bit sampled low, character discarded.
- char_count  output  32  number of good characters received.

Behaviour:
- Clock and reset: clock clk; reset is synchronous, active-high.
- Reset values: state IDLE, synchroniser flops = 1, rx_valid=0, rx_data=0, rx_break=0, frame_err=0, char_count=0, all counters 0.
- Synchroniser: rxd passes through SYNC_STAGES flops to give rs. A registered copy rs_d is used for edge detection.
- Bit period: cpb_l is latched on the start-edge cycle. If cycles_per_bit < 4, cpb_l = 4. Changing cycles_per_bit mid-frame has no effect until the next start edge.
- Timing within a bit:
  - Cycle counter cc runs 0..cpb_l-1, then wraps; the bit index advances on the wrap.
  - half = cpb_l>>1.
  - Samples are taken at cc = half-1, half and half+1.
  - The bit value is the majority of the 3 samples and is decided at cc = half+1.
- IDLE:
  - Wait for rs_d=1 and rs=0 (falling edge) with rx_en=1.
  - On that cycle: cc<=0, latch cpb_l, go to START.
- START:
  - If the majority is 1 (false start / glitch), go to IDLE with no strobe.
  - Otherwise, at cc = cpb_l-1 go to DATA with bit index 0.
- DATA:
  - 8 bits, LSB first, shifted into a shift register at each majority decision.
  - After bit 7 ends, go to STOP.
- STOP: at the majority decision, one of three outcomes:
  - Stop=1: rx_data<=shift, rx_valid=1 for exactly one cycle (the next cycle), char_count<=char_count+1 (wraps at 2^32-1 -> 0), go to IDLE immediately. There is no wait for stop-bit end, so back-to-back characters are accepted.
  - Stop=0 and shift!=0: frame_err=1 for one cycle, rx_data and char_count unchanged, go to BRK_WAIT.
  - Stop=0 and shift==0: rx_break<=1, go to BRK_WAIT. No valid and no frame_err.
- BRK_WAIT:
  - Stay until rs=1 for half consecutive cycles.
  - Then clear rx_break and go to IDLE.
  - Prevents false start edges on a low line.
- rx_valid is never high for more than one consecutive cycle. This is required because the consumer FSM queues once per rx_valid cycle.
- rx_en=0: next clock forces IDLE and clears rx_break. A partial character is discarded with no strobes. char_count and rx_data are held.
- Reset mid-frame: immediate return to reset values on the next clock; no strobe is emitted.
- Simultaneous events: a reset or rx_en=0 on the stop-decision cycle suppresses the rx_valid and frame_err strobes.
- Latency: rx_valid asserts on the cycle after the half+1 sample of the stop bit. Measured from the start edge at rs, this is about 9.5 bit periods + 2 cycles.

Test Plan:
- Normal character: cpb=8, rx_en=1, send 0x55 with a clean frame -> exactly one rx_valid pulse, rx_data=0x55, char_count=1, frame_err=0.
- Glitch rejection: cpb=16, rxd low for 2 cycles then high -> no rx_valid or frame_err; block returns to IDLE and the next frame 0xA3 is received correctly.
- Noise tolerance: cpb=16, send 0x0F with rxd inverted for only the cc=half cycle of bit 2 -> rx_data=0x0F (majority corrects).
- Framing error: cpb=8, send 0xA5 with stop bit low, then release the line -> one frame_err pulse, no rx_valid, rx_data and char_count unchanged.
- Break and back-to-back:
  - Break: hold rxd low for 20 bit times -> rx_break=1 until the line is high for half cycles, then 0.
  - Back-to-back: send 0x31, 0x32 back-to-back -> two single-cycle rx_valid pulses, char_count +2.
- Abort and clamp:
  - Abort: deassert rx_en at bit 4 of 0x7E -> no strobes, state IDLE.
  - Clamp: cycles_per_bit=2 -> behaves as cpb=4.
  - Wrap: preload char_count to 0xFFFFFFFF (force) plus one good character -> char_count=0.
